// File: rtl/prog_mem_if.sv
// Bus between the host/CPU side and the program memory: CPU fetch pins plus
// the byte-wide load port and its status outputs.
interface prog_mem_if #(
  parameter int AW     = 4,
  parameter int WORD_W = 8
);
  logic [AW-1:0]     addr;
  logic [WORD_W-1:0] data;
  logic              ld_start;
  logic              ld_valid;
  logic [WORD_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_error;
  logic              cpu_hold;

  modport master (
    output addr, ld_start, ld_valid, ld_data,
    input  data, ld_ready, ld_done, ld_error, cpu_hold
  );

  modport slave (
    input  addr, ld_start, ld_valid, ld_data,
    output data, ld_ready, ld_done, ld_error, cpu_hold
  );
endinterface

// File: rtl/prog_mem.sv
// Program memory and loader for the 4-bit CPU. Serves fetches combinationally,
// accepts a new program plus trailing checksum over a valid/ready port, and
// holds the CPU in reset until a verified program is present.
module prog_mem #(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic      clock,
  input  logic      reset,
  prog_mem_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

  state_t                        state;
  logic [DEPTH-1:0][WORD_W-1:0]  mem;
  logic [AW-1:0]                 ptr;
  logic [WORD_W-1:0]             sum;
  logic [WORD_W-1:0]             sum_next;
  logic                          ready;
  logic                          done;
  logic                          error;
  logic                          hold;

  // Running checksum including the byte on the bus; a good program sums to zero.
  assign sum_next = sum + bus.ld_data;

  // Fetch path: held CPU sees zeros so a half-loaded program is never executed.
  assign bus.data     = hold ? '0 : mem[bus.addr];
  assign bus.ld_ready = ready;
  assign bus.ld_done  = done;
  assign bus.ld_error = error;
  assign bus.cpu_hold = hold;

  // Loader FSM with registered handshake/status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      sum   <= '0;
      mem   <= '0;
      ready <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
      hold  <= 1'b1;
    end else begin
      done <= 1'b0;
      if (bus.ld_start) begin
        // Start (or restart) wins over any transfer in the same cycle; words
        // already written are left in place and get overwritten by the reload.
        state <= LOAD;
        ptr   <= '0;
        sum   <= '0;
        ready <= 1'b1;
        error <= 1'b0;
        hold  <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          LOAD: begin
            if (bus.ld_valid) begin
              mem[ptr] <= bus.ld_data;
              sum      <= sum_next;
              ptr      <= ptr + AW'(1);
              if (ptr == AW'(DEPTH - 1)) state <= CHECK;
            end
          end
          CHECK: begin
            if (bus.ld_valid) begin
              state <= IDLE;
              ready <= 1'b0;
              if (sum_next == '0) begin
                done <= 1'b1;
                hold <= 1'b0;
              end else begin
                error <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed load scenarios plus randomized
// programs, gaps and checksums against a behavioural model of the memory.
module tb_prog_mem;

  typedef byte unsigned prog_t [16];

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  prog_mem_if bus ();

  prog_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  byte unsigned model_mem [16];
  bit          model_hold;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sweep every address and compare against the model view of the CPU.
  task automatic check_reads(input string tag);
    for (int a = 0; a < 16; a++) begin
      @(negedge clock);
      bus.addr = 4'(a);
      #1;
      chk(tag, bus.data, model_hold ? 8'h00 : model_mem[a]);
    end
  endtask

  task automatic start_load();
    @(negedge clock);
    bus.ld_start = 1'b1;
    bus.ld_valid = 1'($urandom_range(0, 1));  // must be ignored
    bus.ld_data  = 8'($urandom);
    @(negedge clock);
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    model_hold   = 1'b1;
    chk("ready_after_start", bus.ld_ready, 1);
    chk("error_clear_on_start", bus.ld_error, 0);
    chk("hold_on_start", bus.cpu_hold, 1);
  endtask

  // Present one byte, optionally preceded by random idle cycles with junk data.
  task automatic send(input byte unsigned b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        bus.ld_valid = 1'b0;
        bus.ld_data  = 8'($urandom);
        @(negedge clock);
      end
    end
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    chk("ready_in_load", bus.ld_ready, 1);
    @(negedge clock);
  endtask

  task automatic load_body(input prog_t p, input byte unsigned ck, input bit gaps);
    int s;
    bit ok;
    s = 0;
    for (int i = 0; i < 16; i++) begin
      send(p[i], gaps);
      s += int'(p[i]);
    end
    send(ck, gaps);
    bus.ld_valid = 1'b0;
    ok = ((s + int'(ck)) % 256) == 0;
    chk("done_pulse", bus.ld_done, ok);
    chk("error_flag", bus.ld_error, !ok);
    chk("hold_after_check", bus.cpu_hold, !ok);
    chk("ready_fall", bus.ld_ready, 0);
    if (ok) begin
      model_mem  = p;
      model_hold = 1'b0;
    end
    @(negedge clock);
    chk("done_one_cycle", bus.ld_done, 0);
    chk("error_sticky", bus.ld_error, !ok);
  endtask

  task automatic load(input prog_t p, input byte unsigned ck, input bit gaps);
    start_load();
    load_body(p, ck, gaps);
  endtask

  prog_t ramp, pb3, ones, rnd;
  int    s;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ramp[i]      = byte'(i);
      pb3[i]       = 8'hB3;
      ones[i]      = 8'h01;
      model_mem[i] = 8'h00;
    end
    model_hold   = 1'b1;
    reset        = 1'b1;
    bus.addr     = '0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state held through idle cycles.
    repeat (5) begin
      @(negedge clock);
      chk("rst_hold", bus.cpu_hold, 1);
      chk("rst_ready", bus.ld_ready, 0);
      chk("rst_done", bus.ld_done, 0);
      chk("rst_error", bus.ld_error, 0);
    end
    check_reads("rst_data");

    // Valid without ready has no effect while idle.
    @(negedge clock);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h5A;
    @(negedge clock);
    bus.ld_valid = 1'b0;
    chk("idle_valid_ready", bus.ld_ready, 0);

    // Ramp program, good checksum.
    load(ramp, 8'h88, 1'b0);
    check_reads("ramp_data");

    // Bad checksum, then recover with a good load.
    load(ramp, 8'h00, 1'b0);
    check_reads("bad_ck_data");
    load(ramp, 8'h88, 1'b0);
    check_reads("recover_data");

    // Gapped load of 0xB3.
    load(pb3, 8'hD0, 1'b1);
    check_reads("b3_data");

    // Restart after 7 words, then all-ones program.
    start_load();
    for (int i = 0; i < 7; i++) send(8'($urandom), 1'b1);
    bus.ld_valid = 1'b0;
    start_load();
    load_body(ones, 8'hF0, 1'b0);
    check_reads("restart_data");

    // Reset while waiting for the checksum.
    start_load();
    for (int i = 0; i < 16; i++) send(ramp[i], 1'b0);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 8'h88;
    reset        = 1'b1;
    @(negedge clock);
    reset        = 1'b0;
    bus.ld_valid = 1'b0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_hold = 1'b1;
    chk("rstchk_ready", bus.ld_ready, 0);
    chk("rstchk_done", bus.ld_done, 0);
    chk("rstchk_error", bus.ld_error, 0);
    chk("rstchk_hold", bus.cpu_hold, 1);
    @(negedge clock);
    chk("rstchk_done2", bus.ld_done, 0);
    chk("rstchk_error2", bus.ld_error, 0);
    check_reads("rstchk_data");

    // Random programs with random gaps; checksum right or deliberately off.
    repeat (6) begin
      s = 0;
      for (int i = 0; i < 16; i++) begin
        rnd[i] = 8'($urandom);
        s += int'(rnd[i]);
      end
      s = (256 - (s % 256)) % 256;
      if ($urandom_range(0, 2) == 0) s = (s + int'($urandom_range(1, 255))) % 256;
      load(rnd, 8'(s), 1'b1);
      check_reads("rand_data");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
# prog_mem

Program memory and loader for the 4-bit CPU: the responder side of the CPU instruction-fetch interface.
- Holds sixteen 8-bit instruction words and serves fetches combinationally from the CPU address.
- Accepts a new program over a byte-wide valid/ready load port, verifies it with an 8-bit checksum, and holds the CPU in reset until a verified program is present.
- Sits between the top-level host/loader logic and the CPU's `addr`/`data` pins.

## Interface
Parameters:
- `DEPTH`, 16: number of instruction words; the address width is log2(DEPTH) = 4.
- `WORD_W`, 8: instruction word width, {opcode[7:4], imm[3:0]}.

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  4  CPU fetch address.
- `data`  out  8  instruction word at `addr`.
- `ld_start`  in  1  one-cycle request to begin a program load.
- `ld_valid`  in  1  `ld_data` is valid.
- `ld_data`  in  8  load byte (program word or checksum).
- `ld_ready`  out  1  block accepts `ld_data` this cycle.
- `ld_done`  out  1  one-cycle pulse: load verified.
- `ld_error`  out  1  sticky: checksum mismatch.
- `cpu_hold`  out  1  high = keep CPU in reset. The top level inverts it into the CPU's active-low reset.

## Operation
- Storage: 16 x 8 register array `mem`, plus a 4-bit write pointer `ptr` and an 8-bit running sum `sum`.
- Read path:
  - `data = cpu_hold ? 8'h00 : mem[addr]`. This is combinational, with no added latency.
  - The CPU samples `data` in the same cycle it presents `addr`.
- A transfer occurs on any cycle where `ld_valid & ld_ready` are both high.
- States:
  - **IDLE**: `ld_ready`=0. `ld_start` goes to LOAD with `ptr`=0, `sum`=0, `ld_error`=0, `cpu_hold`=1.
  - **LOAD**: `ld_ready`=1. On each transfer:
    - `mem[ptr]` <= `ld_data`.
    - `sum` <= `sum + ld_data`, truncated to 8 bits.
    - `ptr` <= `ptr + 1`.
    - The transfer with `ptr`==15 goes to CHECK. `ptr` wraps to 0.
  - **CHECK**: `ld_ready`=1. On the transfer:
    - If `sum + ld_data` == 8'h00 (mod 256): go to IDLE, pulse `ld_done`, clear `cpu_hold`.
    - Otherwise: go to IDLE, set `ld_error`, keep `cpu_hold`=1.
- `ld_start` in LOAD or CHECK restarts the load: `ptr`=0, `sum`=0, state LOAD. Any transfer in that same cycle is ignored, and words already written are not cleared.
- `ld_start` and a transfer in the same cycle while IDLE: the start wins. The byte is not accepted, because `ld_ready` was 0.
- `ld_valid` without `ld_ready` has no effect.
- `ld_data` may change freely while no transfer occurs.
- `ld_error` stays high until the next `ld_start` or `reset`.
- `cpu_hold` is cleared only by a verified load.

## Timing
- Reset values (synchronous, applied on the clock edge where `reset`=1, overriding all other inputs):
  - state IDLE, `ptr`=0, `sum`=0, every `mem` word 8'h00.
  - `ld_ready`=0, `ld_done`=0, `ld_error`=0, `cpu_hold`=1, so `data`=8'h00.
- `ld_ready` is a registered state decode.
  - It rises the cycle after `ld_start` is sampled.
  - It falls the cycle after the checksum transfer.
- A write is visible on `data` (when unheld) starting the cycle after its transfer edge.
- A full load takes at minimum 1 start cycle + 16 word transfers + 1 checksum transfer.
  - `ld_done` is high for exactly the cycle after the checksum edge.
  - `cpu_hold` falls in that same cycle.
- Reset during LOAD or CHECK aborts the load.
  - Memory is cleared.
  - No `ld_done` or `ld_error` is produced.
- `ld_done` and `ld_error` are never high in the same cycle.

## Test plan
- Reset, then idle 5 cycles: `cpu_hold`=1, `data`=0x00 for every `addr`, `ld_ready`=0, `ld_done`=0, `ld_error`=0.
- Load words 0x00..0x0F back-to-back, then checksum 0x88: `ld_done` pulses 1 cycle and `cpu_hold` falls in that cycle. Afterwards `addr`=5 gives `data`=0x05 and `addr`=15 gives `data`=0x0F.
- Same load with checksum 0x00 (sum 0x78): `ld_error`=1, `cpu_hold` stays 1, `data`=0x00. A following correct load (0x88) clears `ld_error` and pulses `ld_done`.
- Random `ld_valid` gaps over a 16-word load of all 0xB3, then checksum 0xD0 (16 x 0xB3 = 0x30 mod 256): only valid cycles are stored, `ld_done` pulses, and every `addr` reads 0xB3.
- Pulse `ld_start` after 7 words, then load 16 words of 0x01 plus checksum 0xF0: `ld_done` pulses, `mem` is all 0x01, and the aborted partial words are overwritten.
- Assert `reset` during CHECK: next cycle state is IDLE, `mem` is all 0x00, `cpu_hold`=1, and neither `ld_done` nor `ld_error` pulses.
